// File: rtl/apb_i2c_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb_i2c_bridge
//  Purpose  : APB3 slave front end for an I2C master. Each APB transfer is
//             turned into one byte request on the master's bus port; the APB
//             access is held (PREADY low) until the master reports completion
//             or a watchdog expires, then the result is returned with a
//             single-cycle PREADY pulse.
//
//  Ports    : clk, reset             - clock, asynchronous active-high reset
//             psel, penable, pwrite,
//             paddr, pwdata          - APB3 request side
//             prdata, pready,
//             pslverr                - APB3 completion side (registered)
//             i2c_ce, i2c_wren,
//             i2c_rden, i2c_addr,
//             i2c_wdata              - request toward the I2C master (registered)
//             i2c_rdata, i2c_error,
//             i2c_ready              - completion from the I2C master
//
//  Revision : 1.0 - initial release
// ============================================================================
module apb_i2c_bridge #(
   parameter int TIMEOUT = 1023,   // max REQ cycles before abort (1..65535)
   parameter int TW      = 16      // watchdog counter width, 2**TW > TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   // APB3 slave
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   // I2C master request port
   output logic       i2c_ce,
   output logic       i2c_wren,
   output logic       i2c_rden,
   output logic [7:0] i2c_addr,
   output logic [7:0] i2c_wdata,
   input  logic [7:0] i2c_rdata,
   input  logic       i2c_error,
   input  logic       i2c_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Counter value seen in the last permitted REQ cycle. The counter is
   // cleared on entry to REQ, so hitting this value means TIMEOUT cycles
   // have been spent in REQ.
   localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

   state_t          r_state;
   logic [TW-1:0]   r_cnt;
   logic            r_write;     // direction of the in-flight request
   logic [7:0]      r_rdata;     // last byte read from the master

   // Only a genuine setup phase starts a transfer; an access phase seen
   // without its setup phase is ignored.
   logic w_setup;
   assign w_setup = psel & ~penable;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_write   <= 1'b0;
         r_rdata   <= 8'h00;
         prdata    <= 8'h00;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         i2c_ce    <= 1'b0;
         i2c_wren  <= 1'b0;
         i2c_rden  <= 1'b0;
         i2c_addr  <= 8'h00;
         i2c_wdata <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_setup) begin
                  r_write   <= pwrite;
                  i2c_addr  <= paddr;
                  i2c_wdata <= pwdata;
                  r_cnt     <= '0;
                  // Request strobes are registered here so they are stable
                  // for every cycle of REQ.
                  i2c_ce    <= 1'b1;
                  i2c_wren  <= pwrite;
                  i2c_rden  <= ~pwrite;
                  r_state   <= S_REQ;
               end
            end

            S_REQ: begin
               r_cnt <= r_cnt + 1'b1;
               // Completion is tested before the watchdog so a ready strobe
               // arriving in the final permitted cycle still delivers the
               // master's data and status.
               if (i2c_ready) begin
                  if (!r_write) begin
                     r_rdata <= i2c_rdata;
                     prdata  <= i2c_rdata;
                  end else begin
                     // Writes leave the read register untouched and report
                     // its current contents.
                     prdata  <= r_rdata;
                  end
                  pslverr  <= i2c_error;
                  pready   <= 1'b1;
                  i2c_ce   <= 1'b0;
                  i2c_wren <= 1'b0;
                  i2c_rden <= 1'b0;
                  r_state  <= S_RESP;
               end else if (r_cnt == c_TMO_LAST) begin
                  r_rdata  <= 8'h00;
                  prdata   <= 8'h00;
                  pslverr  <= 1'b1;
                  pready   <= 1'b1;
                  i2c_ce   <= 1'b0;
                  i2c_wren <= 1'b0;
                  i2c_rden <= 1'b0;
                  r_state  <= S_RESP;
               end
            end

            S_RESP: begin
               // Response data is only visible during the PREADY cycle.
               pready  <= 1'b0;
               prdata  <= 8'h00;
               pslverr <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               pready   <= 1'b0;
               prdata   <= 8'h00;
               pslverr  <= 1'b0;
               i2c_ce   <= 1'b0;
               i2c_wren <= 1'b0;
               i2c_rden <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
